// File: rtl/jt51_shram_ctrl.sv
// Makes an external simple dual-port RAM behave as a cen-gated, stages-deep
// shift register, with a post-reset flush and idle-cycle host reads.
module jt51_shram_ctrl #(
   parameter int   width  = 5,
   parameter int   stages = 32,
   parameter logic rstval = 1'b0,
   parameter int   aw     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cen,
   input  logic [width-1:0] din,
   output logic [width-1:0] drop,
   output logic             ready,
   output logic [aw-1:0]    mem_raddr,
   input  logic [width-1:0] mem_rdata,
   output logic [aw-1:0]    mem_waddr,
   output logic [width-1:0] mem_wdata,
   output logic             mem_we,
   input  logic             hreq,
   input  logic [aw-1:0]    haddr,
   output logic             hack,
   output logic [width-1:0] hdata
);

   // state   | meaning
   // S_FLUSH | writing rstval into every stage, one address per clock
   // S_RUN   | normal shifting; idle clocks serve the host
   // H_IDLE  | no host read outstanding
   // H_RD    | host read issued last clock, RAM data arriving now
   // H_ACK   | hack pulse, hdata valid
   typedef enum logic {S_FLUSH, S_RUN} st_t;
   typedef enum logic [1:0] {H_IDLE, H_RD, H_ACK} hst_t;

   localparam logic [aw-1:0]    LAST = aw'(stages - 1);
   localparam logic [aw+1:0]    S1   = (aw+2)'(stages);
   localparam logic [aw+1:0]    S2   = (aw+2)'(2 * stages);
   localparam logic [width-1:0] RV   = {width{rstval}};

   st_t              st_q, st_d;
   hst_t             hst_q, hst_d;
   logic [aw-1:0]    fcnt_q, fcnt_d;
   logic [aw-1:0]    wp_q, wp_d;
   logic [aw-1:0]    rp_q, rp_d;
   logic [width-1:0] drop_q, drop_d;
   logic [width-1:0] hdata_q, hdata_d;
   logic             shpend_q, shpend_d;
   logic             hoor_q, hoor_d;
   logic             ready_q, ready_d;

   logic             shift, issue, oor;
   logic [aw+1:0]    hsum, hred;

   function automatic logic [aw-1:0] inc(input logic [aw-1:0] p);
      return (p == LAST) ? '0 : p + aw'(1);
   endfunction

   always_comb begin
      st_d      = st_q;
      hst_d     = hst_q;
      fcnt_d    = fcnt_q;
      wp_d      = wp_q;
      rp_d      = rp_q;
      drop_d    = drop_q;
      hdata_d   = hdata_q;
      hoor_d    = hoor_q;
      ready_d   = ready_q;
      mem_we    = 1'b0;
      mem_waddr = wp_q;
      mem_wdata = din;
      mem_raddr = rp_q;

      shift = (st_q == S_RUN) && cen;
      issue = (st_q == S_RUN) && (hst_q == H_IDLE) && hreq && !cen;
      oor   = ({1'b0, haddr} >= (aw+1)'(stages));

      // (wp-1-haddr) mod stages, biased by 2*stages to stay non-negative
      hsum = {2'b00, wp_q} + S2 - (aw+2)'(1) - {2'b00, haddr};
      hred = (hsum >= S2) ? hsum - S2 : hsum - S1;

      if (st_q == S_FLUSH) begin
         mem_we    = 1'b1;
         mem_waddr = fcnt_q;
         mem_wdata = RV;
         if (fcnt_q == LAST) begin
            st_d    = S_RUN;
            ready_d = 1'b1;
         end else begin
            fcnt_d = fcnt_q + aw'(1);
         end
      end else if (shift) begin
         mem_we    = 1'b1;
         mem_waddr = wp_q;
         mem_wdata = din;
         mem_raddr = rp_q;
         wp_d      = inc(wp_q);
         rp_d      = inc(rp_q);
      end else if (issue && !oor) begin
         mem_raddr = hred[aw-1:0];
      end

      shpend_d = shift;
      if (shpend_q) drop_d = mem_rdata;

      case (hst_q)
         H_IDLE: if (issue) begin
            hst_d  = H_RD;
            hoor_d = oor;
         end
         H_RD: begin
            hdata_d = hoor_q ? RV : mem_rdata;
            hst_d   = H_ACK;
         end
         default: hst_d = H_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q     <= S_FLUSH;
         hst_q    <= H_IDLE;
         fcnt_q   <= '0;
         wp_q     <= LAST;
         rp_q     <= '0;
         drop_q   <= RV;
         hdata_q  <= RV;
         shpend_q <= 1'b0;
         hoor_q   <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         st_q     <= st_d;
         hst_q    <= hst_d;
         fcnt_q   <= fcnt_d;
         wp_q     <= wp_d;
         rp_q     <= rp_d;
         drop_q   <= drop_d;
         hdata_q  <= hdata_d;
         shpend_q <= shpend_d;
         hoor_q   <= hoor_d;
         ready_q  <= ready_d;
      end
   end

   assign drop  = drop_q;
   assign hdata = hdata_q;
   assign ready = ready_q;
   assign hack  = (hst_q == H_ACK);

endmodule

// File: tb/tb_jt51_shram_ctrl.sv
// Directed bench for jt51_shram_ctrl with a behavioural RAM and a flop-chain
// reference for the delay line.
module tb_jt51_shram_ctrl;
   localparam int W  = 5;
   localparam int ST = 32;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          rst, cen, hreq, ready, hack, mem_we;
   logic [W-1:0]  din, drop, mem_rdata, mem_wdata, hdata;
   logic [AW-1:0] mem_raddr, mem_waddr, haddr;

   jt51_shram_ctrl #(.width(W), .stages(ST), .rstval(1'b0), .aw(AW)) dut (
      .clk(clk), .rst(rst), .cen(cen), .din(din), .drop(drop), .ready(ready),
      .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_we(mem_we), .hreq(hreq), .haddr(haddr),
      .hack(hack), .hdata(hdata)
   );

   always #5 clk = ~clk;

   logic [W-1:0] ram [0:(1<<AW)-1];
   logic         ram_ok = 1'b0;
   always @(posedge clk) begin
      if (!ram_ok) begin
         for (int i = 0; i < (1<<AW); i++) ram[i] <= 5'h15;
         ram_ok <= 1'b1;
      end else begin
         mem_rdata <= ram[mem_raddr];
         if (mem_we) ram[mem_waddr] <= mem_wdata;
      end
   end

   int cmps = 0;
   int errs = 0;

   logic [W-1:0] chain [ST];
   logic [W-1:0] exp_drop;
   logic         pend, m_flush;
   int           m_fcnt, npulse;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmps++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: advance the reference on the edge, then check drop/ready.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < ST; i++) chain[i] = '0;
         exp_drop = '0; pend = 1'b0; m_flush = 1'b1; m_fcnt = 0; npulse = 0;
      end else if (m_flush) begin
         if (m_fcnt == ST-1) m_flush = 1'b0;
         else m_fcnt++;
      end else begin
         if (pend) exp_drop = chain[ST-1];
         if (cen) begin
            for (int i = ST-1; i > 0; i--) chain[i] = chain[i-1];
            chain[0] = din;
            npulse++;
         end
         pend = cen;
      end
      #1;
      chk("drop", 32'(drop), 32'(exp_drop));
      chk("ready", 32'(ready), 32'(!m_flush));
   endtask

   task automatic do_reset();
      rst = 1'b1; hreq = 1'b0; cen = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic host_read(input logic [AW-1:0] a, input logic [W-1:0] exp, input bit cen_in_rd);
      hreq = 1'b1; haddr = a;
      #1;
      if (a < ST) chk("issue_raddr", 32'(mem_raddr), 32'(((ST-1+npulse-1-int'(a)) % ST + ST) % ST));
      tick();
      chk("hack_rd", 32'(hack), 0);
      if (cen_in_rd) begin cen = 1'b1; din = 5'h1a; end
      tick();
      cen = 1'b0;
      chk("hack_ack", 32'(hack), 1);
      chk("hdata", 32'(hdata), 32'(exp));
      hreq = 1'b0;
      tick();
      chk("hack_end", 32'(hack), 0);
   endtask

   initial begin
      rst = 1'b1; cen = 1'b0; hreq = 1'b0; din = '0; haddr = '0;
      m_flush = 1'b1; m_fcnt = 0; npulse = 0; pend = 1'b0; exp_drop = '0;
      for (int i = 0; i < ST; i++) chain[i] = '0;
      #2;

      // reset flush
      do_reset();
      chk("rst_hack", 32'(hack), 0);
      chk("rst_hdata", 32'(hdata), 0);
      for (int i = 0; i < ST; i++) begin
         chk("flush_we", 32'(mem_we), 1);
         chk("flush_waddr", 32'(mem_waddr), 32'(i));
         chk("flush_wdata", 32'(mem_wdata), 0);
         tick();
      end
      chk("ready_up", 32'(ready), 1);

      // cen every third clock, din = pulse index
      for (int p = 0; p < 40; p++) begin
         cen = 1'b1; din = W'(p % 32);
         tick();
         cen = 1'b0;
         tick();
         tick();
      end
      chk("delay_p39", 32'(drop), 8);

      // back-to-back shifts
      for (int i = 0; i < 100; i++) begin
         cen = 1'b1; din = W'($urandom);
         tick();
      end
      cen = 1'b0;
      tick();

      // host reads after 40 shifts of din=k
      do_reset();
      for (int i = 0; i < ST; i++) tick();
      for (int k = 0; k < 40; k++) begin
         cen = 1'b1; din = W'(k);
         tick();
      end
      cen = 1'b0;
      tick();
      chk("idle_raddr", 32'(mem_raddr), 32'(npulse % ST));
      host_read(8'd0, 5'd39, 1'b0);
      host_read(8'd5, 5'd34, 1'b0);

      // request raised during a shift waits; shift during H_RD keeps snapshot
      hreq = 1'b1; haddr = 8'd3; cen = 1'b1; din = 5'h10;
      tick();
      chk("defer_hack", 32'(hack), 0);
      cen = 1'b0;
      host_read(8'd3, 5'd37, 1'b1);

      // out-of-range stage index
      host_read(8'd40, 5'd0, 1'b0);

      // reset during H_RD, then again at fcnt=10
      hreq = 1'b1; haddr = 8'd0; cen = 1'b0;
      tick();
      rst = 1'b1; hreq = 1'b0;
      tick();
      rst = 1'b0;
      chk("mid_hack", 32'(hack), 0);
      chk("mid_waddr0", 32'(mem_waddr), 0);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("mid_hack_fl", 32'(hack), 0);
      end
      chk("mid_waddr10", 32'(mem_waddr), 10);
      do_reset();
      chk("restart_waddr", 32'(mem_waddr), 0);
      for (int i = 0; i < ST-1; i++) begin
         tick();
         chk("rdy_low", 32'(ready), 0);
      end
      tick();
      chk("rdy_rise", 32'(ready), 1);
      chk("final_hack", 32'(hack), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule

// File: doc/jt51_shram_ctrl.md
Name: jt51_shram_ctrl

Overview:
Controller for a block-RAM implementation of the JT51 per-slot delay line (the 32-stage, cen-gated operator/channel pipeline registers). It drives an external simple dual-port RAM so that the RAM behaves exactly like a `stages`-deep flop shift register. It also performs the post-reset flush that a RAM cannot do in one clock. On idle (cen=0) clocks it lets a debug/host requester read any stage through the RAM read port.

Parameters:
width, 5, data bits per stage
stages, 32, delay depth in cen pulses; legal range 2..256
rstval, 1'b0, value replicated across all bits of every stage after reset
aw, 8, RAM address width; requires 2^aw >= stages

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cen  in  1  clock enable; one shift per cen=1 clock
din  in  width  data shifted in on cen
drop  out  width  data leaving the delay line
ready  out  1  high once the flush is complete
mem_raddr  out  aw  RAM read address; combinational from internal state
mem_rdata  in  width  RAM read data; valid one clk after mem_raddr
mem_waddr  out  aw  RAM write address
mem_wdata  out  width  RAM write data
mem_we  out  1  RAM write strobe
hreq  in  1  host read request; level, held until hack
haddr  in  aw  host stage index; 0 = newest written, stages-1 = oldest
hack  out  1  one-clock pulse; hdata is valid in the same clock
hdata  out  width  host read result

Behaviour:
- Reset: rst is sampled on posedge clk only. On the edge where rst=1:
  - State goes to FLUSH; fcnt=0; wp=stages-1; rp=0.
  - drop={width{rstval}}; hdata={width{rstval}}; hack=0; ready=0.
  - Any host transaction in flight is abandoned with no hack.
  - rst asserted during FLUSH restarts the flush from fcnt=0.
- Pointers: wp and rp are modulo-stages counters. rp = wp+1 mod stages at all times.
- FLUSH state (cen ignored):
  - Each clk: mem_we=1, mem_waddr=fcnt, mem_wdata={width{rstval}}, then fcnt++.
  - After the write at fcnt=stages-1, go to RUN and set ready=1 on that edge. The flush takes exactly `stages` clocks.
  - drop holds rstval. hreq is not accepted.
- RUN, shift (cen=1):
  - mem_we=1, mem_waddr=wp, mem_wdata=din, mem_raddr=rp; wp and rp advance by 1.
  - On the next clk edge, drop loads mem_rdata, then holds until the next shift load.
  - Equivalence rule: after the load that follows cen pulse n, drop equals din from cen pulse n-(stages-1). This is identical to a flop chain.
- RUN, cen=0: mem_we=0. The read port belongs to the host FSM.
- Host FSM states: H_IDLE, H_RD, H_ACK.
  - H_IDLE -> H_RD when RUN, hreq=1 and cen=0. In that clock mem_raddr = (wp-1-haddr) mod stages.
  - If cen=1, the request waits. cen always has priority.
  - H_RD: hdata <= mem_rdata, then go to H_ACK.
  - H_ACK: hack=1 for this clock, then H_IDLE.
  - Latency from the issue clock to hack is 2 clocks.
- Host reads during shifts: a cen pulse during H_RD or H_ACK still shifts normally. The host data captured is the pre-shift snapshot.
- Out-of-range request: haddr >= stages skips the RAM. hdata={width{rstval}}, and hack pulses 2 clocks after acceptance.
- Outputs when idle: mem_raddr=rp when neither a shift nor a host issue is active. No output is X after reset.
- Back-to-back shifts: cen=1 on consecutive clocks is legal. The drop load for pulse n and the read for pulse n+1 overlap correctly. The host is starved until a cen=0 clock.

Test Plan:
- Reset flush: rst 1 clk then idle, stages=32 -> mem_we=1 with addresses 0..31 and wdata=0; ready rises after clock 32; drop=0 throughout.
- Delay equivalence: cen every 3rd clk, din=pulse index mod 32 -> after pulse n>=31, drop==(n-31) mod 32. The result matches a reference flop shift register cycle-for-cycle.
- Back-to-back cen: cen=1 continuously for 100 clks with random din -> drop sequence equals din delayed by 31 pulses, no dropped or duplicated values.
- Host read: 40 shifts of din=k, cen low, hreq with haddr=0 and then haddr=5 -> hack 2 clks after issue; hdata=39, then hdata=34.
- Host vs cen: hreq raised in a cen=1 clock -> issue deferred to the next cen=0 clock. haddr=40 (stages=32) -> hdata=rstval, hack still pulses.
- Reset mid-operation: rst during H_RD and again at fcnt=10 of a flush -> no hack; flush restarts at 0 and ready rises 32 clks after the last rst.
